// File: rtl/i2s_sample_framer_pkg.sv
// i2s_sample_framer_pkg: shared sample width, stereo pair type and framer states
package i2s_sample_framer_pkg;
  localparam int I2S_DW = 24;
  typedef struct packed {logic [I2S_DW-1:0] l, r;} stereo_t;
  typedef enum logic {WAIT_L, WAIT_R} framer_state_t;
endpackage

// File: rtl/i2s_sample_framer_sync_fifo.sv
// i2s_sample_framer_sync_fifo: single-clock FIFO, flags derived from registered pointers only
module i2s_sample_framer_sync_fifo #(
  parameter int W = 48,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  always_ff @(posedge clk_i)
    if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + (AW+1)'(1);
      if (pop_i) rd_q <= rd_q + (AW+1)'(1);
    end
  assign data_o = mem_q[rd_q[AW-1:0]];
  assign level_o = wr_q - rd_q;
  assign full_o = level_o == (AW+1)'(DEPTH);
  assign empty_o = level_o == '0;
endmodule

// File: rtl/i2s_sample_framer.sv
// i2s_sample_framer: pairs a mono L/R stream into stereo frames and serves them to i2s_tx
module i2s_sample_framer
  import i2s_sample_framer_pkg::*;
#(
  parameter int DW = I2S_DW,
  parameter int DEPTH = 8,
  parameter int CW = 16,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [DW-1:0] s_data_i,
  input  logic          s_valid_i,
  input  logic          s_last_i,
  output logic          s_ready_o,
  input  logic          rd_en_i,
  output logic          rd_valid_o,
  output logic [DW-1:0] l_sample_o,
  output logic [DW-1:0] r_sample_o,
  output logic [LW-1:0] level_o,
  output logic          sync_err_o,
  output logic [CW-1:0] underrun_cnt_o
);
  framer_state_t state_q, state_d;
  logic [DW-1:0] l_hold_q, l_hold_d, l_q, r_q;
  logic [CW-1:0] und_q;
  logic rv_q, err_q, err_d, push, full, empty, xfer;
  logic [2*DW-1:0] head;
  assign s_ready_o = (state_q == WAIT_L) | !full;
  assign xfer = s_valid_i & s_ready_o;
  always_comb begin
    state_d = state_q;
    l_hold_d = l_hold_q;
    err_d = 1'b0;
    push = 1'b0;
    if (xfer) begin
      if (state_q == WAIT_L) begin
        err_d = s_last_i;
        l_hold_d = s_last_i ? l_hold_q : s_data_i;
        state_d = s_last_i ? WAIT_L : WAIT_R;
      end else begin
        push = s_last_i;
        err_d = !s_last_i;
        l_hold_d = s_last_i ? l_hold_q : s_data_i;
        state_d = s_last_i ? WAIT_L : WAIT_R;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= WAIT_L;
      l_hold_q <= '0;
      err_q <= 1'b0;
      rv_q <= 1'b0;
      l_q <= '0;
      r_q <= '0;
      und_q <= '0;
    end else begin
      state_q <= state_d;
      l_hold_q <= l_hold_d;
      err_q <= err_d;
      rv_q <= rd_en_i;
      if (rd_en_i) {l_q, r_q} <= empty ? '0 : head;
      if (rd_en_i & empty & ~&und_q) und_q <= und_q + CW'(1);
    end
  // no bypass: a pair written this cycle is not visible to a same-cycle read
  i2s_sample_framer_sync_fifo #(.W(2*DW), .DEPTH(DEPTH)) u_fifo (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .push_i(push),
    .data_i({l_hold_q, s_data_i}),
    .pop_i(rd_en_i & !empty),
    .data_o(head),
    .full_o(full),
    .empty_o(empty),
    .level_o(level_o)
  );
  assign rd_valid_o = rv_q;
  assign l_sample_o = l_q;
  assign r_sample_o = r_q;
  assign sync_err_o = err_q;
  assign underrun_cnt_o = und_q;
endmodule

// File: tb/tb_i2s_sample_framer.sv
// tb_i2s_sample_framer: vector table, directed corner sequences and random traffic vs a queue model
module tb_i2s_sample_framer;
  logic clk = 0, rst_ni = 0;
  logic [23:0] s_data = '0, l_sample, r_sample;
  logic s_valid = 0, s_last = 0, rd_en = 0, s_ready, rd_valid, sync_err;
  logic [3:0] level;
  logic [15:0] underrun_cnt;
  int total = 0, passed = 0;

  i2s_sample_framer dut (
    .clk_i(clk), .rst_ni(rst_ni), .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last),
    .s_ready_o(s_ready), .rd_en_i(rd_en), .rd_valid_o(rd_valid), .l_sample_o(l_sample),
    .r_sample_o(r_sample), .level_o(level), .sync_err_o(sync_err), .underrun_cnt_o(underrun_cnt)
  );

  always #5 clk = ~clk;

  logic [47:0] q[$];
  logic have_left = 0;
  logic [23:0] hold = 0, m_l = 0, m_r = 0;
  logic m_rv = 0, m_se = 0;
  int m_und = 0;

  typedef struct {
    logic v; logic [23:0] d; logic l; logic rd;
    logic erv; logic [23:0] el, er; logic [3:0] elv; logic ese; logic [15:0] eu;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    q.delete();
    have_left = 0; hold = 0; m_l = 0; m_r = 0; m_rv = 0; m_se = 0; m_und = 0;
  endtask

  task automatic step(input logic v, input logic [23:0] d, input logic l, input logic r);
    logic exp_ready, pushv;
    logic [47:0] pair;
    @(negedge clk);
    s_valid = v; s_data = d; s_last = l; rd_en = r;
    exp_ready = !have_left || q.size() < 8;
    chk("s_ready", {63'd0, s_ready}, {63'd0, exp_ready});
    @(posedge clk); #1;
    m_se = 0; pushv = 0; pair = '0;
    if (v && exp_ready) begin
      if (!have_left) begin
        if (!l) begin hold = d; have_left = 1; end
        else m_se = 1;
      end else if (l) begin
        pushv = 1; pair = {hold, d}; have_left = 0;
      end else begin
        hold = d; m_se = 1;
      end
    end
    m_rv = r;
    if (r) begin
      if (q.size() == 0) begin
        m_l = 0; m_r = 0;
        if (m_und < 65535) m_und++;
      end else {m_l, m_r} = q.pop_front();
    end
    if (pushv) q.push_back(pair);
    chk("rd_valid", {63'd0, rd_valid}, {63'd0, m_rv});
    chk("l_sample", {40'd0, l_sample}, {40'd0, m_l});
    chk("r_sample", {40'd0, r_sample}, {40'd0, m_r});
    chk("level", {60'd0, level}, 64'(q.size()));
    chk("sync_err", {63'd0, sync_err}, {63'd0, m_se});
    chk("underrun", {48'd0, underrun_cnt}, 64'(m_und));
  endtask

  initial begin
    tbl[0]  = '{1, 24'h1,  0, 0, 0, 24'h0,  24'h0,  4'd0, 0, 16'd0};
    tbl[1]  = '{1, 24'h2,  1, 0, 0, 24'h0,  24'h0,  4'd1, 0, 16'd0};
    tbl[2]  = '{0, 24'h0,  0, 1, 1, 24'h1,  24'h2,  4'd0, 0, 16'd0};
    tbl[3]  = '{1, 24'h5,  1, 0, 0, 24'h1,  24'h2,  4'd0, 1, 16'd0};
    tbl[4]  = '{1, 24'hA,  0, 0, 0, 24'h1,  24'h2,  4'd0, 0, 16'd0};
    tbl[5]  = '{1, 24'hB,  0, 0, 0, 24'h1,  24'h2,  4'd0, 1, 16'd0};
    tbl[6]  = '{1, 24'hC,  1, 0, 0, 24'h1,  24'h2,  4'd1, 0, 16'd0};
    tbl[7]  = '{0, 24'h0,  0, 1, 1, 24'hB,  24'hC,  4'd0, 0, 16'd0};
    tbl[8]  = '{1, 24'h11, 0, 0, 0, 24'hB,  24'hC,  4'd0, 0, 16'd0};
    tbl[9]  = '{1, 24'h22, 1, 1, 1, 24'h0,  24'h0,  4'd1, 0, 16'd1};
    tbl[10] = '{0, 24'h0,  0, 1, 1, 24'h11, 24'h22, 4'd0, 0, 16'd1};
    tbl[11] = '{0, 24'h0,  0, 1, 1, 24'h0,  24'h0,  4'd0, 0, 16'd2};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("rst_level", {60'd0, level}, 64'd0);
    chk("rst_underrun", {48'd0, underrun_cnt}, 64'd0);
    chk("rst_l", {40'd0, l_sample}, 64'd0);
    @(negedge clk) rst_ni = 1;
    #1 chk("rst_ready", {63'd0, s_ready}, 64'd1);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].rd);
      chk($sformatf("tbl%0d_rv", i), {63'd0, rd_valid}, {63'd0, tbl[i].erv});
      chk($sformatf("tbl%0d_l", i), {40'd0, l_sample}, {40'd0, tbl[i].el});
      chk($sformatf("tbl%0d_r", i), {40'd0, r_sample}, {40'd0, tbl[i].er});
      chk($sformatf("tbl%0d_lvl", i), {60'd0, level}, {60'd0, tbl[i].elv});
      chk($sformatf("tbl%0d_se", i), {63'd0, sync_err}, {63'd0, tbl[i].ese});
      chk($sformatf("tbl%0d_und", i), {48'd0, underrun_cnt}, {48'd0, tbl[i].eu});
    end

    for (int i = 0; i < 8; i++) begin
      step(1, 24'h100 + 24'(i), 0, 0);
      step(1, 24'h200 + 24'(i), 1, 0);
    end
    step(1, 24'h108, 0, 0);
    chk("full_ready", {63'd0, s_ready}, 64'd0);
    chk("full_level", {60'd0, level}, 64'd8);
    step(1, 24'h208, 1, 1);
    chk("full_pop_l", {40'd0, l_sample}, 64'h100);
    chk("full_pop_r", {40'd0, r_sample}, 64'h200);
    chk("ready_after_pop", {63'd0, s_ready}, 64'd1);
    step(1, 24'h208, 1, 0);
    chk("ninth_level", {60'd0, level}, 64'd8);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    chk("drained_l", {40'd0, l_sample}, 64'h108);
    for (int i = 0; i < 20; i++) begin
      step(1, 24'h300 + 24'(i), 0, 0);
      step(1, 24'h400 + 24'(i), 1, i % 3 != 0);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) step(0, 0, 0, 1);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, 24'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 4) < 2);
    for (int i = 0; i < 10 && q.size() > 0; i++) step(0, 0, 0, 1);

    @(negedge clk);
    s_valid = 0; rd_en = 1;
    repeat (65541) @(posedge clk);
    #1;
    chk("underrun_sat", {48'd0, underrun_cnt}, 64'hFFFF);
    chk("underrun_zero_l", {40'd0, l_sample}, 64'd0);
    m_und = 65535; m_l = 0; m_r = 0;
    step(0, 0, 0, 1);
    chk("underrun_hold", {48'd0, underrun_cnt}, 64'hFFFF);

    step(1, 24'h51, 0, 0);
    step(1, 24'h52, 1, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 24'h600 + 24'(i), 0, 0);
      step(1, 24'h700 + 24'(i), 1, 0);
    end
    step(1, 24'h6FF, 0, 0);
    chk("pre_rst_level", {60'd0, level}, 64'd3);
    @(negedge clk);
    s_valid = 0; rd_en = 0;
    #2 rst_ni = 0;
    #1;
    chk("mid_rst_level", {60'd0, level}, 64'd0);
    chk("mid_rst_l", {40'd0, l_sample}, 64'd0);
    chk("mid_rst_r", {40'd0, r_sample}, 64'd0);
    chk("mid_rst_und", {48'd0, underrun_cnt}, 64'd0);
    chk("mid_rst_rv", {63'd0, rd_valid}, 64'd0);
    model_reset();
    @(negedge clk) rst_ni = 1;
    step(1, 24'h77, 1, 0);
    chk("post_rst_sync_err", {63'd0, sync_err}, 64'd1);
    step(1, 24'h78, 0, 0);
    step(1, 24'h79, 1, 1);
    step(0, 0, 0, 1);
    chk("post_rst_pair", {16'd0, l_sample, r_sample}, 64'h000078_000079);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
